// File: rtl/draw_player_ctl_gen_if.sv
// draw_player_ctl_gen_if
//   Bundle between the input decoder / player draw stage and the player
//   position controller.
//   master : input decoder side, drives v_tick, m_left, m_right, gate_open
//            and observes the controller outputs
//   slave  : controller side, drives xpos, state, blocked, frame_upd
//   v_tick    frame tick level (rising edge = new frame)
//   m_left    move-left request
//   m_right   move-right request
//   gate_open per-zone passable flags
//   xpos      player x position
//   state     IDLE=0, RIGHT=1, LEFT=2, BLOCKED=3
//   blocked   state==BLOCKED
//   frame_upd one-cycle pulse after each update
interface draw_player_ctl_gen_if #(
    parameter int XW      = 12,
    parameter int N_GATES = 2
);
    logic               v_tick;
    logic               m_left;
    logic               m_right;
    logic [N_GATES-1:0] gate_open;
    logic [XW-1:0]      xpos;
    logic [1:0]         state;
    logic               blocked;
    logic               frame_upd;

    modport master (
        output v_tick, m_left, m_right, gate_open,
        input  xpos, state, blocked, frame_upd
    );

    modport slave (
        input  v_tick, m_left, m_right, gate_open,
        output xpos, state, blocked, frame_upd
    );
endinterface

// File: rtl/draw_player_ctl_gen.sv
// draw_player_ctl_gen
//   Per-frame horizontal position controller for the player sprite.
//   On each rising edge of v_tick the player moves STEP pixels in the
//   requested direction (right wins over left), saturates at the screen
//   limits and is stopped at the boundary of any closed gate zone it is
//   not already inside.
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    draw_player_ctl_gen_if.slave (v_tick, m_left, m_right,
//          gate_open in; xpos, state, blocked, frame_upd out)
module draw_player_ctl_gen #(
    parameter int                     XW      = 12,
    parameter int                     X_MIN   = 0,
    parameter int                     X_MAX   = 660,
    parameter int                     X_INIT  = 0,
    parameter int                     STEP    = 1,
    parameter int                     N_GATES = 2,
    parameter logic [N_GATES*XW-1:0]  GATE_LO = {12'd520, 12'd310},
    parameter logic [N_GATES*XW-1:0]  GATE_HI = {12'd560, 12'd450}
) (
    input logic                  clk,
    input logic                  rst_n,
    draw_player_ctl_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RIGHT   = 2'd1,
        LEFT    = 2'd2,
        BLOCKED = 2'd3
    } state_t;

    // Arithmetic is one bit wider than the position so xpos+STEP never wraps.
    localparam int XW1 = XW + 1;
    localparam logic [XW:0] LIM_MAX  = XW1'(X_MAX);
    localparam logic [XW:0] LIM_MIN  = XW1'(X_MIN);
    localparam logic [XW:0] STEP_X   = XW1'(STEP);
    localparam logic [XW:0] MIN_STEP = XW1'(X_MIN + STEP);

    logic          v_tick_q;
    logic [XW-1:0] x_q;
    state_t        st_q;
    logic          blk_q;
    logic          upd_q;

    logic          frame_edge;
    logic [XW:0]   cur;
    logic [XW:0]   sum_r;
    logic [XW:0]   cand_r;
    logic [XW:0]   cand_l;
    logic          hit_r;
    logic          hit_l;
    logic [XW:0]   clamp_lo;
    logic [XW:0]   clamp_hi;
    logic [XW:0]   lo;
    logic [XW:0]   hi;
    logic          in_zone;
    logic [XW-1:0] x_nx;
    state_t        st_nx;

    assign frame_edge = bus.v_tick & ~v_tick_q;
    assign cur        = {1'b0, x_q};

    always_comb begin
        sum_r    = cur + STEP_X;
        cand_r   = (sum_r > LIM_MAX) ? LIM_MAX : sum_r;
        // Left saturation tested before subtracting so it cannot underflow.
        cand_l   = (cur < MIN_STEP) ? LIM_MIN : cur - STEP_X;
        hit_r    = 1'b0;
        hit_l    = 1'b0;
        clamp_lo = '0;
        clamp_hi = '0;
        lo       = '0;
        hi       = '0;
        in_zone  = 1'b0;
        for (int g = 0; g < N_GATES; g++) begin
            lo      = {1'b0, GATE_LO[g*XW +: XW]};
            hi      = {1'b0, GATE_HI[g*XW +: XW]};
            in_zone = (cur >= lo) && (cur <= hi);
            // A player standing inside a closed zone is never trapped.
            if (!bus.gate_open[g] && !in_zone) begin
                if (cur < lo && lo <= cand_r && (!hit_r || lo < clamp_lo)) begin
                    hit_r    = 1'b1;
                    clamp_lo = lo;
                end
                if (cand_l <= hi && hi < cur && (!hit_l || hi > clamp_hi)) begin
                    hit_l    = 1'b1;
                    clamp_hi = hi;
                end
            end
        end

        x_nx  = x_q;
        st_nx = IDLE;
        if (bus.m_right) begin
            x_nx  = hit_r ? XW'(clamp_lo - 1'b1) : XW'(cand_r);
            st_nx = hit_r ? BLOCKED : RIGHT;
        end else if (bus.m_left) begin
            x_nx  = hit_l ? XW'(clamp_hi + 1'b1) : XW'(cand_l);
            st_nx = hit_l ? BLOCKED : LEFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_tick_q <= 1'b0;
            x_q      <= XW'(X_INIT);
            st_q     <= IDLE;
            blk_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            v_tick_q <= bus.v_tick;
            upd_q    <= frame_edge;
            if (frame_edge) begin
                x_q   <= x_nx;
                st_q  <= st_nx;
                blk_q <= (st_nx == BLOCKED);
            end
        end
    end

    assign bus.xpos      = x_q;
    assign bus.state     = st_q;
    assign bus.blocked   = blk_q;
    assign bus.frame_upd = upd_q;
endmodule
